// File: rtl/score_display_pkg.sv
// Shared types and constants for the score_display slice: FSM states,
// active-low seven-segment codes and display geometry.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned DIG_SEL_W = 2;
  localparam int unsigned BCD_W     = 20;

  // Cathodes {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Score input and display output bundle; master is the score source,
// slave is the display block.
interface score_display_if #(
  parameter int unsigned SCORE_W = 16
);
  logic [SCORE_W-1:0] score;
  logic [3:0]         an;
  logic [6:0]         seg;
  logic               dp;
  logic               busy;

  modport master (output score, input an, seg, dp, busy);
  modport slave  (input score, output an, seg, dp, busy);
endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, SCORE_W shifts,
// then a one-cycle DONE with the BCD result held on bcd.
module bin2bcd_seq
  import score_display_pkg::*;
#(
  parameter int unsigned SCORE_W = 16,
  parameter int unsigned BCD_W   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic [BCD_W-1:0]   bcd,
  output logic               done
);

  localparam int unsigned CNT_W = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCORE_W - 1);

  state_t               state_q;
  logic [SCORE_W-1:0]   bin_q;
  logic [BCD_W-1:0]     bcd_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 busy_q;
  logic                 done_q;

  logic [BCD_W-1:0]         adj;
  logic [BCD_W+SCORE_W-1:0] sh;

  always_comb begin
    adj = bcd_q;
    for (int unsigned i = 0; i < BCD_W / 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    sh = {adj[BCD_W-2:0], bin_q, 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            bin_q   <= bin;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= sh;
          cnt_q          <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/score_display.sv
// Score to 4-digit multiplexed seven-segment display. Optional leading-zero
// blanking is enabled by defining SCORE_DISPLAY_BLANK_EN.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 18,
  parameter int unsigned SCORE_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  score_display_if.slave  dif
);

  logic [SCORE_W-1:0]      shown_src_q;
  logic [SCORE_W-1:0]      pend_q;
  logic [BCD_W-1:0]        digits_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [3:0]              an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    start;
  logic                    conv_busy;
  logic                    conv_done;
  logic [BCD_W-1:0]        conv_bcd;

  // Compare against the last converted value so a change that lands while
  // busy is picked up again on the first idle cycle.
  assign start = (dif.score != shown_src_q);

  bin2bcd_seq #(
    .SCORE_W (SCORE_W),
    .BCD_W   (BCD_W)
  ) u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (dif.score),
    .busy  (conv_busy),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shown_src_q <= '0;
      pend_q      <= '0;
      digits_q    <= '0;
    end else begin
      if (start && !conv_busy) pend_q <= dif.score;
      if (conv_done) begin
        digits_q    <= conv_bcd;
        shown_src_q <= pend_q;
      end
    end
  end

  logic [DIG_SEL_W-1:0] sel;
  logic [3:0]           dig [5];
  logic                 ovf;
`ifdef SCORE_DISPLAY_BLANK_EN
  logic                 blank;
`endif

  always_comb begin
    for (int unsigned i = 0; i < 5; i++) dig[i] = digits_q[4*i +: 4];
    sel   = refresh_q[REFRESH_BITS-1 -: DIG_SEL_W];
    ovf   = (dig[4] != 4'd0);
    an_d  = '1;
    an_d[sel] = 1'b0;
    seg_d = seg_encode(dig[sel]);
    dp_d  = !(ovf && (sel == 2'd3));
`ifdef SCORE_DISPLAY_BLANK_EN
    blank = 1'b0;
    if (!ovf) begin
      unique case (sel)
        2'd3:    blank = (dig[3] == 4'd0);
        2'd2:    blank = (dig[3] == 4'd0) && (dig[2] == 4'd0);
        2'd1:    blank = (dig[3] == 4'd0) && (dig[2] == 4'd0) && (dig[1] == 4'd0);
        default: blank = 1'b0;
      endcase
    end
    if (blank) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_q <= '0;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      refresh_q <= refresh_q + 1'b1;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  assign dif.an   = an_q;
  assign dif.seg  = seg_q;
  assign dif.dp   = dp_q;
  assign dif.busy = conv_busy;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display with a short refresh counter so a full
// scan takes 16 cycles.
module tb_score_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  score_display_if #(.SCORE_W(16)) dif ();

  score_display #(
    .REFRESH_BITS (4),
    .SCORE_W      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of_digit(input int unsigned d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] seg_for(input int unsigned val, input logic [3:0] an);
    case (an)
      4'b1110: return seg_of_digit(val % 10);
      4'b1101: return seg_of_digit((val / 10) % 10);
      4'b1011: return seg_of_digit((val / 100) % 10);
      4'b0111: return seg_of_digit((val / 1000) % 10);
      default: return 7'h7F;
    endcase
  endfunction

  task automatic scan_check(input string tag, input int unsigned val);
    logic [3:0] slot;
    for (int s = 0; s < 4; s++) begin
      slot = ~(4'b0001 << s);
      for (int i = 0; i < 32; i++) begin
        @(negedge clk);
        if (dif.an === slot) break;
      end
      check({tag, "_an"},  32'(dif.an),  32'(slot));
      check({tag, "_seg"}, 32'(dif.seg), 32'(seg_for(val, slot)));
      check({tag, "_dp"},  32'(dif.dp),  32'((val >= 10000 && slot == 4'b0111) ? 1'b0 : 1'b1));
    end
  endtask

  task automatic busy_count(input string tag, input int unsigned exp);
    int unsigned n = 0;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      if (dif.busy === 1'b1) n++;
    end
    check(tag, 32'(n), 32'(exp));
  endtask

`ifdef SCORE_DISPLAY_BLANK_EN
  task automatic blank_check(input string tag, input int unsigned val);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check({tag, "_an"}, 32'((dif.an === 4'b1110) || (dif.an === 4'b1111)), 32'd1);
      check({tag, "_seg"}, 32'(dif.seg), 32'((dif.an === 4'b1110) ? seg_for(val, 4'b1110) : 7'h7F));
    end
  endtask
`endif

  initial begin
    dif.score = 16'd0;

    // Reset held with score 0
    repeat (3) @(negedge clk);
    check("rst_an",   32'(dif.an),   32'hF);
    check("rst_seg",  32'(dif.seg),  32'h7F);
    check("rst_dp",   32'(dif.dp),   32'h1);
    check("rst_busy", 32'(dif.busy), 32'h0);
    rst = 1'b1;
    busy_count("zero_busy", 0);
`ifdef SCORE_DISPLAY_BLANK_EN
    blank_check("zero", 0);
`else
    scan_check("zero", 0);
`endif

    // 1234: 17 busy cycles, then the four digits on their anodes
    @(negedge clk);
    dif.score = 16'd1234;
    busy_count("d1234_busy", 17);
    scan_check("d1234", 1234);

    // 65535: overflow nibble set, dp low on digit 3 only
    @(negedge clk);
    dif.score = 16'd65535;
    busy_count("d65535_busy", 17);
    scan_check("d65535", 65535);

    // 100 then 200 sampled at edge k+5: second capture at k+18, done at k+35
    @(negedge clk);
    dif.score = 16'd100;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dif.score = 16'd200;
    repeat (12) @(negedge clk);
    check("b2b_busy_k16", 32'(dif.busy), 32'h1);
    @(negedge clk);
    check("b2b_busy_k17", 32'(dif.busy), 32'h0);
    @(negedge clk);
    check("b2b_busy_k18", 32'(dif.busy), 32'h1);
    check("b2b_seg_100",  32'(dif.seg),  32'(seg_for(100, dif.an)));
    repeat (16) @(negedge clk);
    check("b2b_busy_k34", 32'(dif.busy), 32'h1);
    @(negedge clk);
    check("b2b_busy_k35", 32'(dif.busy), 32'h0);
    scan_check("d200", 200);

    // 7: leading digits blanked only when blanking is built in
    @(negedge clk);
    dif.score = 16'd7;
    busy_count("d7_busy", 17);
`ifdef SCORE_DISPLAY_BLANK_EN
    blank_check("d7", 7);
`else
    scan_check("d7", 7);
`endif

    // Reset mid-conversion with 9999
    @(negedge clk);
    dif.score = 16'd9999;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_an",   32'(dif.an),   32'hF);
    check("mid_rst_seg",  32'(dif.seg),  32'h7F);
    check("mid_rst_dp",   32'(dif.dp),   32'h1);
    check("mid_rst_busy", 32'(dif.busy), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    busy_count("d9999_busy", 17);
    scan_check("d9999", 9999);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("d9999_onehot", 32'($countones(~dif.an)), 32'd1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
